// File: rtl/usi_dma_hs_bridge.sv
// DMA handshake bridge between one USI instance and a DMAC RX/TX channel pair.
// Optional macro USI_DMA_TRUST_GATE_EN: requests are gated by trust, and loss of trust aborts an active request.
module usi_dma_hs_bridge #(
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 200,
  parameter int HOLDOFF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       usi_req_rx,
  input  logic       usi_req_tx,
  output logic       usi_ack_rx,
  output logic       usi_ack_tx,
  output logic       dmac_req_rx,
  output logic       dmac_req_tx,
  input  logic       dmac_ack_rx,
  input  logic       dmac_ack_tx,
  input  logic       trust,
  input  logic [1:0] err_clr,
  output logic [1:0] err_sts,
  output logic       err_intr
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACK, ST_HOLD} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] HOLD_LOAD = TMO_W'(HOLDOFF - 1);

  logic [1:0] usi_req_v;
  logic [1:0] dmac_ack_v;
  logic [1:0] dmac_req_v;
  logic [1:0] usi_ack_v;
  logic [1:0] new_err;
  logic [1:0] err_sts_reg;
  logic [1:0] err_sts_next;
  logic       err_intr_reg;
  logic       trust_ok;

  assign usi_req_v  = {usi_req_tx, usi_req_rx};
  assign dmac_ack_v = {dmac_ack_tx, dmac_ack_rx};

`ifdef USI_DMA_TRUST_GATE_EN
  assign trust_ok = trust;
`else
  logic unused_trust;
  assign unused_trust = trust;
  assign trust_ok     = 1'b1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      state_t           state_reg;
      logic [TMO_W-1:0] cnt_reg;
      logic             dmac_req_reg;
      logic             usi_ack_reg;
      logic             timeout;
      logic             abort;

      // An ack arriving on the last REQ cycle wins over the timeout.
      always_comb begin
        abort   = 1'b0;
        timeout = 1'b0;
        if (state_reg == ST_REQ) begin
          abort   = ~trust_ok;
          timeout = ~dmac_ack_v[gi] && (cnt_reg == TMO_LAST);
        end
      end

      assign new_err[gi] = abort | timeout;

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg    <= ST_IDLE;
          cnt_reg      <= '0;
          dmac_req_reg <= 1'b0;
          usi_ack_reg  <= 1'b0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              if (usi_req_v[gi] && trust_ok) begin
                state_reg    <= ST_REQ;
                cnt_reg      <= '0;
                dmac_req_reg <= 1'b1;
              end
            end
            ST_REQ: begin
              if (abort || timeout) begin
                state_reg    <= ST_HOLD;
                cnt_reg      <= HOLD_LOAD;
                dmac_req_reg <= 1'b0;
              end else if (dmac_ack_v[gi]) begin
                state_reg    <= ST_ACK;
                dmac_req_reg <= 1'b0;
                usi_ack_reg  <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
            ST_ACK: begin
              state_reg   <= ST_HOLD;
              cnt_reg     <= HOLD_LOAD;
              usi_ack_reg <= 1'b0;
            end
            default: begin
              // Hold-off: requests are ignored until the countdown expires.
              if (cnt_reg == '0) begin
                state_reg <= ST_IDLE;
              end else begin
                cnt_reg <= cnt_reg - 1'b1;
              end
            end
          endcase
        end
      end

      assign dmac_req_v[gi] = dmac_req_reg;
      assign usi_ack_v[gi]  = usi_ack_reg;
    end
  endgenerate

  // A new error in the same cycle as its clear keeps the bit set.
  assign err_sts_next = (err_sts_reg & ~err_clr) | new_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sts_reg  <= '0;
      err_intr_reg <= 1'b0;
    end else begin
      err_sts_reg  <= err_sts_next;
      err_intr_reg <= |err_sts_next;
    end
  end

  assign dmac_req_rx = dmac_req_v[0];
  assign dmac_req_tx = dmac_req_v[1];
  assign usi_ack_rx  = usi_ack_v[0];
  assign usi_ack_tx  = usi_ack_v[1];
  assign err_sts     = err_sts_reg;
  assign err_intr    = err_intr_reg;

endmodule

// File: tb/tb_usi_dma_hs_bridge.sv
// Self-checking bench for usi_dma_hs_bridge: directed scenarios plus randomized traffic against an event-time model.
module tb_usi_dma_hs_bridge;

  localparam int TMO_W   = 8;
  localparam int TMO_CYC = 200;
  localparam int HOLDOFF = 2;
`ifdef USI_DMA_TRUST_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] usi_req  = 2'b00;
  logic [1:0] dmac_ack = 2'b00;
  logic [1:0] err_clr  = 2'b00;
  logic       trust    = 1'b1;
  logic       usi_ack_rx, usi_ack_tx, dmac_req_rx, dmac_req_tx, err_intr;
  logic [1:0] err_sts;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  usi_dma_hs_bridge #(.TMO_W(TMO_W), .TMO_CYC(TMO_CYC), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst),
    .usi_req_rx(usi_req[0]), .usi_req_tx(usi_req[1]),
    .usi_ack_rx(usi_ack_rx), .usi_ack_tx(usi_ack_tx),
    .dmac_req_rx(dmac_req_rx), .dmac_req_tx(dmac_req_tx),
    .dmac_ack_rx(dmac_ack[0]), .dmac_ack_tx(dmac_ack[1]),
    .trust(trust), .err_clr(err_clr), .err_sts(err_sts), .err_intr(err_intr)
  );

  // Reference model: a channel is either outstanding (with an age) or
  // waiting until the absolute cycle at which a request may be sampled again.
  bit       m_act [2];
  int       m_age [2];
  int       m_idle_at [2];
  bit [1:0] m_ack;
  bit [1:0] m_err;
  int       m_cyc = 0;

  function automatic void model_step();
    bit nerr;
    bit tok;
    tok = !GATE || trust;
    for (int ch = 0; ch < 2; ch++) begin
      nerr = 1'b0;
      m_ack[ch] = 1'b0;
      if (rst) begin
        m_act[ch]     = 1'b0;
        m_age[ch]     = 0;
        m_idle_at[ch] = m_cyc + 1;
        m_err[ch]     = 1'b0;
      end else begin
        if (m_act[ch]) begin
          if (!tok) begin
            m_act[ch] = 1'b0; nerr = 1'b1; m_idle_at[ch] = m_cyc + HOLDOFF + 1;
          end else if (dmac_ack[ch]) begin
            m_act[ch] = 1'b0; m_ack[ch] = 1'b1; m_idle_at[ch] = m_cyc + HOLDOFF + 2;
          end else if (m_age[ch] == TMO_CYC - 1) begin
            m_act[ch] = 1'b0; nerr = 1'b1; m_idle_at[ch] = m_cyc + HOLDOFF + 1;
          end else begin
            m_age[ch]++;
          end
        end else if (m_cyc >= m_idle_at[ch] && usi_req[ch] && tok) begin
          m_act[ch] = 1'b1;
          m_age[ch] = 0;
        end
        m_err[ch] = (m_err[ch] & ~err_clr[ch]) | nerr;
      end
    end
    m_cyc++;
  endfunction

  function automatic logic [6:0] exp_vec();
    return {m_act[1], m_act[0], m_ack, |m_err, m_err};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {dmac_req_tx, dmac_req_rx, usi_ack_tx, usi_ack_rx, err_intr, err_sts};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; usi_req = 0; dmac_ack = 0; err_clr = 0; trust = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++;
    if (dut_vec() !== 7'd0) begin
      fails++; $display("FAIL reset outputs got=%b exp=%b", dut_vec(), 7'd0);
    end
    tests++;
    if (dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset model got=%b exp=%b", dut_vec(), exp_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_rx();
    logic [31:0] req_mask = 0, ack_mask = 0;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      usi_req[0] = (k == 0);
      dmac_ack[0] = (k == 5);
      tick();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL basic_rx cyc=%0d got=%b exp=%b", k + 1, dut_vec(), exp_vec());
      end
      req_mask[k+1] = dmac_req_rx;
      ack_mask[k+1] = usi_ack_rx;
    end
    tests++;
    if (req_mask !== 32'h3E) begin
      fails++; $display("FAIL basic_rx req_cycles got=%h exp=%h", req_mask, 32'h3E);
    end
    tests++;
    if (ack_mask !== 32'h40 || err_sts !== 2'b00) begin
      fails++; $display("FAIL basic_rx ack_cycles got=%h/%b exp=%h/00", ack_mask, err_sts, 32'h40);
    end
  endtask

  task automatic test_holdoff();
    int ack_c = -1, rise_c = -1;
    logic prev = 1'b0;
    apply_reset();
    usi_req[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      dmac_ack[0] = (k == 5);
      tick();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL holdoff cyc=%0d got=%b exp=%b", k + 1, dut_vec(), exp_vec());
      end
      if (usi_ack_rx) ack_c = k + 1;
      if (ack_c >= 0 && rise_c < 0 && dmac_req_rx && !prev) rise_c = k + 1;
      prev = dmac_req_rx;
    end
    usi_req = 0; dmac_ack = 0;
    tests++;
    if (ack_c < 0 || rise_c - ack_c != HOLDOFF + 2) begin
      fails++; $display("FAIL holdoff gap got=%0d exp=%0d", rise_c - ack_c, HOLDOFF + 2);
    end
  endtask

  task automatic test_timeout();
    int hi = 0, acks = 0;
    apply_reset();
    for (int k = 0; k < TMO_CYC + 20; k++) begin
      usi_req[0] = (k == 0);
      tick();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL timeout cyc=%0d got=%b exp=%b", k + 1, dut_vec(), exp_vec());
      end
      hi += int'(dmac_req_rx);
      acks += int'(usi_ack_rx);
    end
    tests++;
    if (hi != TMO_CYC || acks != 0) begin
      fails++; $display("FAIL timeout req_len got=%0d acks=%0d exp=%0d acks=0", hi, acks, TMO_CYC);
    end
    tests++;
    if (err_sts !== 2'b01 || err_intr !== 1'b1) begin
      fails++; $display("FAIL timeout err got=%b/%b exp=01/1", err_sts, err_intr);
    end
    err_clr = 2'b01;
    tick();
    err_clr = 2'b00;
    tests++;
    if (err_sts !== 2'b00 || err_intr !== 1'b0) begin
      fails++; $display("FAIL timeout clear got=%b/%b exp=00/0", err_sts, err_intr);
    end
  endtask

  task automatic test_clear_collision();
    int seen = 0;
    apply_reset();
    err_clr = 2'b10;
    for (int k = 0; k < TMO_CYC + 10; k++) begin
      usi_req[1] = (k == 0);
      tick();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL clear_collision cyc=%0d got=%b exp=%b", k + 1, dut_vec(), exp_vec());
      end
      seen += int'(err_sts[1]);
    end
    err_clr = 2'b00;
    tests++;
    if (seen != 1) begin
      fails++; $display("FAIL clear_collision set_cycles got=%0d exp=1", seen);
    end
  endtask

  task automatic test_ack_at_timeout();
    int ack_c = -1;
    apply_reset();
    for (int k = 0; k < TMO_CYC + 6; k++) begin
      usi_req[0] = (k == 0);
      dmac_ack[0] = (k == TMO_CYC);
      tick();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL ack_at_timeout cyc=%0d got=%b exp=%b", k + 1, dut_vec(), exp_vec());
      end
      if (usi_ack_rx) ack_c = k + 1;
    end
    tests++;
    if (ack_c != TMO_CYC + 1 || err_sts !== 2'b00) begin
      fails++; $display("FAIL ack_at_timeout got=%0d/%b exp=%0d/00", ack_c, err_sts, TMO_CYC + 1);
    end
  endtask

  task automatic test_concurrency();
    int rx_c = -1, tx_c = -1;
    apply_reset();
    for (int k = 0; k < 15; k++) begin
      usi_req = (k == 0) ? 2'b11 : 2'b00;
      dmac_ack = {k == 7, k == 3};
      tick();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL concurrency cyc=%0d got=%b exp=%b", k + 1, dut_vec(), exp_vec());
      end
      if (usi_ack_rx) rx_c = k + 1;
      if (usi_ack_tx) tx_c = k + 1;
    end
    tests++;
    if (rx_c != 4 || tx_c != 8) begin
      fails++; $display("FAIL concurrency ack_cycles got=%0d,%0d exp=4,8", rx_c, tx_c);
    end
  endtask

  task automatic test_reset_mid();
    logic any_ack = 1'b0;
    apply_reset();
    usi_req[1] = 1'b1;
    tick();
    usi_req[1] = 1'b0;
    tick(); tick();
    tests++;
    if (dmac_req_tx !== 1'b1) begin
      fails++; $display("FAIL reset_mid precondition got=%b exp=1", dmac_req_tx);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (dut_vec() !== 7'd0) begin
      fails++; $display("FAIL reset_mid outputs got=%b exp=%b", dut_vec(), 7'd0);
    end
    dmac_ack[1] = 1'b1;
    tick();
    any_ack |= usi_ack_tx;
    dmac_ack[1] = 1'b0;
    tick();
    any_ack |= usi_ack_tx;
    tests++;
    if (any_ack !== 1'b0 || dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset_mid late_ack got=%b/%b exp=0/%b", any_ack, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_ack_ignored();
    apply_reset();
    dmac_ack = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++;
      if (dut_vec() !== 7'd0) begin
        fails++; $display("FAIL ack_ignored cyc=%0d got=%b exp=%b", k + 1, dut_vec(), 7'd0);
      end
    end
    dmac_ack = 2'b00;
  endtask

  task automatic test_trust();
    int hi = 0;
    apply_reset();
    trust = 1'b0;
    usi_req[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      hi += int'(dmac_req_rx);
    end
    usi_req[0] = 1'b0;
    trust = 1'b1;
    tests++;
    if (hi != (GATE ? 0 : 5)) begin
      fails++; $display("FAIL trust_gate req_cycles got=%0d exp=%0d", hi, GATE ? 0 : 5);
    end
    apply_reset();
    usi_req[0] = 1'b1;
    tick();
    usi_req[0] = 1'b0;
    tick();
    trust = 1'b0;
    tick();
    trust = 1'b1;
    tests++;
    if ({dmac_req_rx, err_sts[0]} !== (GATE ? 2'b01 : 2'b10)) begin
      fails++; $display("FAIL trust_drop got=%b exp=%b", {dmac_req_rx, err_sts[0]}, GATE ? 2'b01 : 2'b10);
    end
    tests++;
    if (dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL trust_drop model got=%b exp=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 2500; k++) begin
      rst      = ($urandom_range(0, 399) == 0);
      usi_req  = {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0};
      dmac_ack = {$urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0};
      err_clr  = {$urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0};
      trust    = GATE ? ($urandom_range(0, 19) != 0) : 1'($urandom_range(0, 1));
      tick();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL random cyc=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_rx();
    test_holdoff();
    test_timeout();
    test_clear_collision();
    test_ack_at_timeout();
    test_concurrency();
    test_reset_mid();
    test_ack_ignored();
    test_trust();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
